ready_valid_register: RTL and testbench
=======================================

# ready_valid_register

Single-stage pipeline register with a valid/ready handshake on both sides and a one-entry skid slot. It sits between a producer and a consumer and cuts the combinational path on both data/valid (forward) and ready (backward). The upstream side sees a plain registered ready. The downstream side sees registered valid and data.

## Interface
- `WIDTH`, default 8, data width in bits (≥1).
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  upstream has data on `in_data`.
- `in_ready`  output  1  block accepts data; registered, no combinational path from `out_ready`.
- `in_data`  input  WIDTH  upstream data.
- `out_valid`  output  1  `out_data` holds a valid word; registered.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `out_data`  output  WIDTH  registered output word.

## Operation
- Transfer on either side: `valid && ready` sampled at a rising edge.
- Storage: `main` register, which drives `out_data`, and `skid` register (WIDTH each).
- FSM states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - BUSY: `main` valid, `skid` empty, `out_valid`=1, `in_ready`=1.
  - FULL: both valid, `out_valid`=1, `in_ready`=0.
- EMPTY:
  - `in_valid`=1: `main`←`in_data`, go to BUSY.
  - Otherwise stay.
- BUSY:
  - `in_valid`=1, `out_ready`=1: `main`←`in_data`, stay BUSY.
  - `in_valid`=1, `out_ready`=0: `skid`←`in_data`, go to FULL.
  - `in_valid`=0, `out_ready`=1: go to EMPTY. `main` keeps its stale value.
  - Neither: stay. `main` holds.
- FULL:
  - `out_ready`=1: `main`←`skid`, go to BUSY.
  - `in_valid` is ignored, since `in_ready`=0.
- Ordering: words leave in arrival order. No word is dropped or duplicated.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` do not change.
- `out_data` is don't-care when `out_valid`=0, but is never X after reset.
- Reset, whenever asserted, including mid-transfer or in FULL:
  - Immediately, with no clock: state EMPTY, `out_valid`=0, `in_ready`=1, `out_data`=0, `skid`=0.
  - Any word in flight is discarded.
- Upstream must not depend on `in_ready` to drive `in_valid`. Downstream may assert `out_ready` independently of `out_valid`.

## Timing
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: one word per cycle sustained while `out_ready`=1.
- Backpressure:
  - `in_ready` falls one edge after the first stalled accept, on entry to FULL.
  - It rises one edge after `out_ready` drains FULL.
  - The skid slot absorbs the one word accepted during that one-cycle lag.
- Outputs are flop-driven only. No input-to-output combinational path.
- First transfer possible at the first rising edge after `rst` deasserts.

## Configuration
- `READY_VALID_REGISTER_ASSERTIONS_EN`: when defined, compiles in concurrent assertions, all `disable iff (!rst)`:
  - `out_valid && !out_ready |=> out_valid && $stable(out_data)`.
  - `!in_ready |-> $past(in_ready) || $past(!in_ready)`, i.e. never X.
  - `$rose(!in_ready) |-> $past(in_valid && !out_ready)`.
  - FULL and EMPTY are never true together.
- When not defined: no assertion code. RTL behaviour is identical.

## Test plan
- Reset: hold `rst`=0, toggle inputs → `out_valid`=0, `in_ready`=1, `out_data`=0. Assert `rst`=0 asynchronously while in FULL → outputs return to these values within 1 ns, no clock needed.
- Streaming: `out_ready`=1, `in_valid`=1, data 1,2,3…100 → `out_data` shows 1..100 on consecutive cycles, one cycle behind input, `in_ready` stays 1.
- Stall:
  - Send 0xA5 then 0x3C with `out_ready`=0 → state FULL, `in_ready`=0, `out_data`=0xA5 held stable.
  - Then `out_ready`=1 for 2 cycles → 0xA5 then 0x3C delivered, `in_ready` returns to 1.
- Ignored input in FULL: while FULL, drive `in_valid`=1 with 0xFF → 0xFF never appears on the output.
- Bubbles: random `in_valid`/`out_ready` with ~50% duty each, 10000 cycles → a scoreboard queue matches every output word in order, with no loss or duplication.
- Idle drain: one word 0x11, then `in_valid`=0, `out_ready`=1 → `out_valid` is 1 for exactly one cycle, then 0.

Source files
------------

// File: rtl/ready_valid_register.sv
// ready_valid_register: single-stage valid/ready pipeline register with a one-entry skid slot.
// Cuts the forward path (out_valid/out_data) and the backward path (in_ready) with flops.
// Ports: clk, rst (async, active-low), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream. WIDTH sets the data width.
// Define READY_VALID_REGISTER_ASSERTIONS_EN to compile in protocol assertions.
module ready_valid_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    // Encoding chosen so bit 0 is in_ready and bit 1 is out_valid: both outputs come straight off flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b01,
        BUSY  = 2'b11,
        FULL  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    assign in_ready  = state_q[0];
    assign out_valid = state_q[1];
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_valid) begin
                main_d  = in_data;
                state_d = BUSY;
            end
            BUSY: if (in_valid && out_ready) begin
                main_d = in_data;
            end else if (in_valid) begin
                // Stalled accept: in_ready is still 1 this cycle, so the word lands in the skid slot.
                skid_d  = in_data;
                state_d = FULL;
            end else if (out_ready) begin
                state_d = EMPTY;
            end
            FULL: if (out_ready) begin
                main_d  = skid_q;
                state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef READY_VALID_REGISTER_ASSERTIONS_EN
    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        out_valid && !out_ready |=> out_valid && $stable(out_data));
    a_ready_known: assert property (@(posedge clk) disable iff (!rst)
        !in_ready |-> $past(in_ready) || $past(!in_ready));
    a_ready_fall: assert property (@(posedge clk) disable iff (!rst)
        $rose(!in_ready) |-> $past(in_valid && !out_ready));
    // FULL is !in_ready, EMPTY is !out_valid.
    a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst)
        !(!in_ready && !out_valid));
`endif
endmodule

// File: tb/tb_ready_valid_register.sv
// tb_ready_valid_register: scoreboard-based bench for ready_valid_register.
module tb_ready_valid_register;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];

    ready_valid_register #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Drives one cycle's inputs at the falling edge; pushes accepted words, reports an output transfer.
    task automatic drive(input bit v, input bit r, input logic [7:0] d, output bit fire);
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        fire = out_valid && r;
        if (v && in_ready) sb.push_back(d);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'(i);
            out_ready = 1'(i >> 1);
            in_data   = 8'($urandom);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold: out_valid=%b in_ready=%b out_data=%h want 0 1 00", out_valid, in_ready, out_data);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        bit fire;
        logic [7:0] exp;
        int pops = 0;
        for (int i = 1; i <= 101; i++) begin
            drive(i <= 100, 1'b1, 8'(i), fire);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready: cycle %0d in_ready=%b want 1", i, in_ready);
            end
            if (i > 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== 8'(i - 1)) begin
                    n_fail++;
                    $display("FAIL stream_lag: cycle %0d out_valid=%b out_data=%0d want 1 %0d", i, out_valid, out_data, i - 1);
                end
            end
            if (fire) begin
                exp = sb.size() != 0 ? sb.pop_front() : 8'hxx;
                pops++;
                n_checks++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL stream_data: got %h want %h", out_data, exp);
                end
            end
            @(posedge clk);
        end
        n_checks++;
        if (pops != 100 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: pops=%0d left=%0d want 100 0", pops, sb.size());
        end
    endtask

    task automatic test_stall();
        bit fire;
        logic [7:0] exp;
        drive(1'b1, 1'b0, 8'hA5, fire);
        @(posedge clk);
        drive(1'b1, 1'b0, 8'h3C, fire);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'hFF, fire);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL stall_full: in_ready=%b out_valid=%b out_data=%h want 0 1 a5", in_ready, out_valid, out_data);
            end
            @(posedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drive(i == 0, 1'b1, 8'hFF, fire);
            n_checks++;
            if (!fire || out_data === 8'hFF) begin
                n_fail++;
                $display("FAIL stall_drain_fire: cycle %0d fire=%b out_data=%h", i, fire, out_data);
            end
            if (fire) begin
                exp = sb.size() != 0 ? sb.pop_front() : 8'hxx;
                n_checks++;
                if (out_data !== exp || exp !== (i == 0 ? 8'hA5 : 8'h3C)) begin
                    n_fail++;
                    $display("FAIL stall_drain_data: got %h scoreboard %h", out_data, exp);
                end
            end
            @(posedge clk);
        end
        drive(1'b0, 1'b0, 8'h00, fire);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_after: in_ready=%b out_valid=%b left=%0d want 1 0 0", in_ready, out_valid, sb.size());
        end
        @(posedge clk);
    endtask

    task automatic test_async_reset();
        bit fire;
        drive(1'b1, 1'b0, 8'h11, fire);
        @(posedge clk);
        drive(1'b1, 1'b0, 8'h22, fire);
        @(posedge clk);
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL areset_pre: in_ready=%b out_data=%h want 0 11", in_ready, out_data);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_now: out_valid=%b in_ready=%b out_data=%h want 0 1 00", out_valid, in_ready, out_data);
        end
        sb.delete();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_idle_drain();
        bit fire;
        logic [7:0] exp;
        drive(1'b1, 1'b1, 8'h11, fire);
        @(posedge clk);
        drive(1'b0, 1'b1, 8'h00, fire);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL drain_one: out_valid=%b out_data=%h want 1 11", out_valid, out_data);
        end
        if (fire) exp = sb.pop_front();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 8'h00, fire);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_idle: cycle %0d out_valid=%b want 0", i, out_valid);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_bubbles();
        bit fire, hold;
        logic [7:0] exp, held;
        hold = 1'b0;
        held = '0;
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), fire);
            if (hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++;
                    $display("FAIL bubble_stable: cycle %0d out_valid=%b out_data=%h want 1 %h", i, out_valid, out_data, held);
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (fire) begin
                exp = sb.size() != 0 ? sb.pop_front() : 8'hxx;
                n_checks++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL bubble_data: cycle %0d got %h want %h", i, out_data, exp);
                end
            end
            @(posedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00, fire);
            if (fire) begin
                exp = sb.size() != 0 ? sb.pop_front() : 8'hxx;
                n_checks++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL bubble_flush: got %h want %h", out_data, exp);
                end
            end
            @(posedge clk);
        end
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_end: left=%0d out_valid=%b want 0 0", sb.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_async_reset();
        test_idle_drain();
        test_bubbles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
